// File: rtl/bus_trace_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : bus_trace_fifo
//  Purpose  : Captures {RW, A, D} of every selected, completed PHI2 bus cycle
//             into a show-ahead FIFO with registered head output. A capture
//             that arrives while the FIFO is full is dropped, and the sticky
//             overflow flag is set. The target bus is never stalled.
//  Options  : TRACE_TIMESTAMP_EN adds a 16-bit PHI2-fall counter. The counter
//             value is prepended to each entry (DW = 41 instead of 25).
//  Revision : 1.0  initial release
// ============================================================================
module bus_trace_fifo #(
  parameter int DEPTH_LOG2 = 4,
`ifdef TRACE_TIMESTAMP_EN
  localparam int DW = 41
`else
  localparam int DW = 25
`endif
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  en,
  input  logic                  PHI2,
  input  logic                  RW,
  input  logic [15:0]           A,
  input  logic [7:0]            D,
  input  logic                  ceN,
  input  logic                  rd,
  output logic [DW-1:0]         dout,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  clr_ovf
);

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic                  phi2_q;
  logic                  rw_q;
  logic [15:0]           a_q;
  logic [7:0]            d_q;
  logic                  ceN_q;
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [DW-1:0]         dout_q, dout_d;
  logic [DW-1:0]         mem_q [DEPTH];

  logic                  w_fall, w_cap, w_pop, w_wr, w_drop, w_head_new;
  logic                  w_empty, w_full;
  logic [DW-1:0]         w_entry;

  assign w_empty = (count_q == '0);
  assign w_full  = (count_q == CNT_FULL);
  assign w_fall  = phi2_q & ~PHI2;

`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] ts_q;

  // Free-running count of PHI2 falling edges, independent of ceN and en
  always_ff @(posedge clk) begin
    if (!rstN)       ts_q <= 16'h0000;
    else if (w_fall) ts_q <= ts_q + 16'h0001;
  end

  assign w_entry = {ts_q, rw_q, a_q, d_q};
`else
  assign w_entry = {rw_q, a_q, d_q};
`endif

  // Bus sampling: PHI2 is tracked every cycle, and bus fields follow only while PHI2 is high
  always_ff @(posedge clk) begin
    if (!rstN) begin
      phi2_q <= 1'b0;
      rw_q   <= 1'b0;
      a_q    <= 16'h0000;
      d_q    <= 8'h00;
      ceN_q  <= 1'b1;
    end else begin
      phi2_q <= PHI2;
      if (PHI2) begin
        rw_q  <= RW;
        a_q   <= A;
        d_q   <= D;
        ceN_q <= ceN;
      end
    end
  end

  // Event decode, pointer/count/flag next state, and next registered head
  always_comb begin
    w_cap   = w_fall & ~ceN_q & en;
    w_pop   = rd & ~w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write
    w_wr    = w_cap & (~w_full | w_pop);
    w_drop  = w_cap & w_full & ~w_pop;
    wptr_d  = w_wr  ? wptr_q + PTR_ONE : wptr_q;
    rptr_d  = w_pop ? rptr_q + PTR_ONE : rptr_q;
    count_d = count_q;
    if (w_wr && !w_pop)      count_d = count_q + CNT_ONE;
    else if (!w_wr && w_pop) count_d = count_q - CNT_ONE;
    // A set takes priority over a simultaneous clear
    ovf_d   = w_drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
    // The new entry becomes the head when nothing else remains in front of it
    w_head_new = w_wr & (w_empty | ((count_q == CNT_ONE) & w_pop));
    dout_d  = dout_q;
    if (w_head_new)          dout_d = w_entry;
    else if (count_d != '0)  dout_d = mem_q[rptr_d];
  end

  // FIFO control state and registered head output
  always_ff @(posedge clk) begin
    if (!rstN) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      dout_q  <= dout_d;
    end
  end

  // Storage array; the contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (w_wr) mem_q[wptr_q] <= w_entry;
  end

  assign dout     = dout_q;
  assign empty    = w_empty;
  assign full     = w_full;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: doc/bus_trace_fifo.md
# bus_trace_fifo

Bus-cycle trace capture stage that sits directly downstream of the address-decode chip select. On every completed PHI2 cycle in which the decoder asserted its active-low chip enable, it records the cycle's RW, address and data into a show-ahead FIFO. The host-side logic drains the FIFO at its own pace. Overflow is flagged rather than stalling the target bus.

## Interface
Parameters:
- DEPTH_LOG2, 4: FIFO depth = 2**DEPTH_LOG2 entries; legal range 1..8.

Derived (localparam, not overridable):
- DW: entry width; 25 without timestamp, 41 with it (see Configuration).

Ports:
- clk  in  1  system clock; all logic is on rising edge.
- rstN  in  1  synchronous active-low reset, sampled on rising clk.
- en  in  1  capture enable; when 0, bus cycles are not recorded.
- PHI2  in  1  target bus phase-2 clock, already synchronized to clk upstream.
- RW  in  1  bus read/write (1 = read), synchronized.
- A  in  16  bus address, synchronized.
- D  in  8  bus data, synchronized.
- ceN  in  1  active-low chip enable from the address decoder, synchronized.
- rd  in  1  pop request; acted on only when empty = 0.
- dout  out  DW  head entry {RW, A, D} (LSB = D[0]); valid while empty = 0.
- empty  out  1  FIFO holds no entries.
- full  out  1  FIFO holds 2**DEPTH_LOG2 entries.
- count  out  DEPTH_LOG2+1  number of stored entries.
- overflow  out  1  sticky: a capture was dropped because the FIFO was full.
- clr_ovf  in  1  clears overflow.

## Operation
- Sampling: phi2_q registers PHI2 every cycle. While PHI2 = 1, rw_q/a_q/d_q/ceN_q register RW/A/D/ceN every cycle. While PHI2 = 0 they hold.
- Event: cap = phi2_q & ~PHI2 & ~ceN_q & en (PHI2 falling edge, bus cycle was selected). The stored entry is the held {rw_q, a_q, d_q}, i.e. the values from the last clk cycle with PHI2 high.
- Write: on cap with full = 0, the entry is stored at wptr and wptr increments mod depth.
- Overflow: on cap with full = 1 and no pop in the same cycle, the entry is dropped and overflow is set.
- Read: on rd with empty = 0, rptr increments. rd while empty is ignored with no side effects.
- Simultaneous cap + pop:
  - When full: the write succeeds, count is unchanged, full stays 1, overflow is not set.
  - When empty: the pop is ignored and the write proceeds.
- Overflow flag: clr_ovf clears it. If a set and clr_ovf occur in the same cycle, set wins.
- en only gates event generation. Toggling en never corrupts stored entries.
- count = entries stored; full = (count == 2**DEPTH_LOG2); empty = (count == 0).
- Pointers are DEPTH_LOG2 bits and wrap naturally from 2**DEPTH_LOG2-1 to 0.

## Timing
- Reset values (rstN = 0 at a rising edge): pointers 0, count 0, empty 1, full 0, overflow 0, dout all zeros, phi2_q 0, ceN_q 1, timestamp 0.
- Reset mid-operation discards all stored entries. No event fires on the first cycle after reset, because phi2_q = 0.
- Capture latency: the event is detected in the cycle where PHI2 is first sampled 0. The entry is written at that rising edge. empty, count and dout update on the same edge, so they are visible one cycle after the event cycle.
- Pop: the rising edge with rd & ~empty advances the head. The new head, or empty = 1, is visible immediately after that edge. dout is registered and has no combinational path from rd.
- Throughput: one capture per PHI2 cycle and one pop per clk cycle can occur concurrently.

## Configuration
- TRACE_TIMESTAMP_EN defined:
  - Adds a 16-bit counter that increments on every PHI2 falling edge, regardless of ceN or en, and wraps FFFF to 0000.
  - Each entry stores the counter value before that edge's increment.
  - DW = 41; dout = {ts[15:0], RW, A, D}.
- TRACE_TIMESTAMP_EN undefined: no counter is present; DW = 25; dout = {RW, A, D}.

## Test plan
- Single write: reset; en = 1; one selected cycle with A = 16'hC012, D = 8'h5A, RW = 0 → one cycle after the PHI2 fall, empty = 0, count = 1, dout = {1'b0, 16'hC012, 8'h5A}. Then rd → empty = 1.
- Unselected cycles: ceN_q = 1 or en = 0 across 4 PHI2 cycles → count stays 0.
- Fill to capacity: DEPTH_LOG2 = 2, 5 selected cycles with no reads → full = 1, count = 4, overflow = 1. Popping 4 entries returns the first 4 addresses in order.
- Simultaneous events when full: full plus cap and rd in the same cycle → overflow stays 0, count stays 4, the new entry appears last.
- Clear contention: clr_ovf asserted in the same cycle as a dropped capture → overflow = 1. Next cycle clr_ovf with no drop → overflow = 0.
- Timestamp (TRACE_TIMESTAMP_EN): 3 unselected PHI2 cycles then 1 selected cycle → dout[40:25] = 16'h0003. Pre-load the counter by running 65 536 cycles → the entry shows 16'h0000 after wrap.
